// File: rtl/rr_channel_arbiter.sv
// Round-robin arbiter: shares one W-bit valid/ready output stage between NCH requesting channels.
// The winner's word is registered with its index, and a one-hot ack pulses when the word is accepted downstream.
module rr_channel_arbiter #(
    parameter int NCH  = 32,
    parameter int W    = 20,
    parameter int SELW = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    chan_en,
    input  logic [NCH*W-1:0]  data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_sel,
    output logic [NCH-1:0]    ack,
    output logic              busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_next;
    logic [SELW-1:0] ptr, ptr_next;
    logic [SELW-1:0] pick_base, pick_idx;
    logic [NCH-1:0]  eligible, cand;
    logic            pick_found, transfer, load;

    assign eligible  = req & chan_en;
    assign out_valid = (state == BUSY);
    assign busy      = (state == BUSY);
    assign transfer  = out_valid & out_ready;

    always_comb begin
        ack = '0;
        if (transfer) ack[out_sel] = 1'b1;
    end

    // On a transfer the next pick starts just past the departing channel and excludes it,
    // which stops a lone requester from monopolising the output.
    always_comb begin
        pick_base = ptr;
        cand      = eligible;
        if (transfer) begin
            pick_base = out_sel + SELW'(1);
            cand      = eligible & ~(NCH'(1) << out_sel);
        end
    end

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!pick_found && cand[pick_base + SELW'(i)]) begin
                pick_found = 1'b1;
                pick_idx   = pick_base + SELW'(i);
            end
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    load       = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (transfer) begin
                    ptr_next = out_sel + SELW'(1);
                    if (pick_found) load = 1'b1;
                    else            state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // data_in is sampled only when a winner is loaded; the held word ignores later changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            out_sel  <= '0;
            out_data <= '0;
        end else begin
            ptr <= ptr_next;
            if (load) begin
                out_sel  <= pick_idx;
                out_data <= data_in[pick_idx*W +: W];
            end
        end
    end

endmodule

// File: tb/tb_rr_channel_arbiter.sv
// Randomized bench for rr_channel_arbiter with a transaction-level round-robin reference model.
module tb_rr_channel_arbiter;

    localparam int NCH  = 32;
    localparam int W    = 20;
    localparam int SELW = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   chan_en;
    logic [NCH*W-1:0] data_in;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [SELW-1:0]  out_sel;
    logic [NCH-1:0]   ack;
    logic             busy;

    int test_count = 0;
    int fail_count = 0;

    // Reference model: the word currently offered downstream and the round-robin start point.
    bit        m_valid;
    int        m_sel;
    bit [W-1:0] m_data;
    int        m_ptr;

    logic [NCH*W-1:0] data_pat;
    localparam logic [NCH-1:0] ALL = '1;

    rr_channel_arbiter #(.NCH(NCH), .W(W), .SELW(SELW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .chan_en(chan_en), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sel(out_sel), .ack(ack), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic int rr_pick(input bit [NCH-1:0] c, input int base);
        for (int i = 0; i < NCH; i++)
            if (c[(base + i) % NCH]) return (base + i) % NCH;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_sel = 0; m_data = '0; m_ptr = 0;
    endtask

    // Compare the DUT against the model for this cycle, then advance the model across the next edge.
    task automatic check_and_advance(input logic [NCH-1:0] r, input logic [NCH-1:0] e, input logic rdy);
        bit [NCH-1:0] elig, c, exp_ack;
        bit xfer;
        int k;
        elig    = r & e;
        xfer    = m_valid && rdy;
        exp_ack = xfer ? (NCH'(1) << m_sel) : '0;
        checkOutput("ack", ack, exp_ack);
        checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
        checkOutput("busy", 32'(busy), 32'(m_valid));
        if (m_valid) begin
            checkOutput("out_sel", 32'(out_sel), 32'(m_sel));
            checkOutput("out_data", 32'(out_data), 32'(m_data));
        end
        if (!m_valid) begin
            k = rr_pick(elig, m_ptr);
        end else if (xfer) begin
            m_ptr = (m_sel + 1) % NCH;
            c = elig;
            c[m_sel] = 1'b0;
            k = rr_pick(c, m_ptr);
            if (k < 0) m_valid = 0;
        end else begin
            k = -1;
        end
        if (k >= 0) begin
            m_valid = 1;
            m_sel   = k;
            m_data  = data_pat[k*W +: W];
        end
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] r, input logic [NCH-1:0] e, input logic rdy);
        @(negedge clk);
        req = r; chan_en = e; out_ready = rdy; data_in = data_pat;
        #1;
        check_and_advance(r, e, rdy);
    endtask

    task automatic randomize_data();
        for (int i = 0; i < NCH; i++) data_pat[i*W +: W] = W'($urandom);
    endtask

    initial begin
        rst_n = 1'b0; req = '0; chan_en = '0; out_ready = 1'b0; data_in = '0;
        data_pat = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset out_valid", 32'(out_valid), 0);
        checkOutput("reset out_sel", 32'(out_sel), 0);
        checkOutput("reset out_data", 32'(out_data), 0);
        checkOutput("reset ack", ack, 0);
        checkOutput("reset busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word from channel 0
        data_pat[0 +: W] = W'(20'h12345);
        applyStimulus(32'h1, ALL, 1'b1);
        applyStimulus(32'h1, ALL, 1'b1);
        applyStimulus(32'h0, ALL, 1'b1);
        applyStimulus(32'h0, ALL, 1'b1);

        // Everyone requesting: full rotation plus wrap
        randomize_data();
        repeat (36) applyStimulus(ALL, ALL, 1'b1);
        applyStimulus('0, ALL, 1'b1);
        applyStimulus('0, ALL, 1'b1);

        // Move ptr to 31, then channels 31 and 0 compete across the wrap
        applyStimulus(32'h4000_0000, ALL, 1'b1);
        applyStimulus('0, ALL, 1'b1);
        repeat (5) applyStimulus(32'h8000_0001, ALL, 1'b1);
        applyStimulus('0, ALL, 1'b1);
        applyStimulus('0, ALL, 1'b1);

        // Stall on channel 5 while its input word keeps changing
        applyStimulus(32'h20, ALL, 1'b0);
        for (int i = 0; i < 4; i++) begin
            data_pat[5*W +: W] = W'($urandom);
            applyStimulus(32'h20, ALL, 1'b0);
        end
        applyStimulus(32'h20, ALL, 1'b1);
        applyStimulus('0, ALL, 1'b1);

        // Disabled channel 0 never wins; lone requester gets one word every other cycle
        repeat (8) applyStimulus(32'h3, 32'hFFFF_FFFE, 1'b1);
        repeat (8) applyStimulus(32'h4, ALL, 1'b1);
        applyStimulus('0, ALL, 1'b1);
        applyStimulus('0, ALL, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            randomize_data();
            applyStimulus(
                (n % 3 == 0) ? NCH'($urandom) : NCH'($urandom & $urandom & $urandom),
                ~NCH'($urandom & $urandom & $urandom),
                ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset while a stalled word is held
        applyStimulus(32'h80, ALL, 1'b0);
        applyStimulus(32'h80, ALL, 1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset out_valid", 32'(out_valid), 0);
        checkOutput("async reset ack", ack, 0);
        checkOutput("async reset busy", 32'(busy), 0);
        model_reset();
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus('0, ALL, 1'b1);
        randomize_data();
        repeat (6) applyStimulus(32'h3000_0001, ALL, 1'b1);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
